// File: rtl/quad_encoder_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_gen_pkg
//  Description : Shared types and constants for the quadrature encoder
//                emulator: state encoding, direction codes and the
//                phase-to-(A,B) Gray mapping used by the generator and the
//                counter benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package quad_encoder_gen_pkg;

   // Controller state; explicit one-bit width so the encoding is fixed.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } qe_state_t;

   // Direction codes match the sign bit of the step command.
   localparam logic c_DIR_FWD = 1'b0;
   localparam logic c_DIR_BWD = 1'b1;

   // (A,B) levels for each quadrature phase, packed as {a, b}.
   localparam logic [1:0] c_AB_PHASE0 = 2'b00;
   localparam logic [1:0] c_AB_PHASE1 = 2'b10;
   localparam logic [1:0] c_AB_PHASE2 = 2'b11;
   localparam logic [1:0] c_AB_PHASE3 = 2'b01;

   // Map a 2-bit phase to its {a, b} levels; adjacent phases differ in one bit.
   function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
      logic [1:0] ab;
      case (phase)
         2'd0:    ab = c_AB_PHASE0;
         2'd1:    ab = c_AB_PHASE1;
         2'd2:    ab = c_AB_PHASE2;
         default: ab = c_AB_PHASE3;
      endcase
      return ab;
   endfunction

endpackage
`default_nettype wire

// File: rtl/quad_encoder_gen_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : quad_step_timer
//  Description : Reloadable down-counter that paces quadrature steps. A load
//                captures the period (zero clamped to one); while running, a
//                tick is produced when the count reaches one and the count is
//                reloaded from the captured period. Abort clears everything.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_step_timer #(
   parameter int DIV_SIZE = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [DIV_SIZE-1:0] i_period,
   input  logic                i_run,
   input  logic                i_abort,
   output logic                o_tick
);

   localparam logic [DIV_SIZE-1:0] c_ONE = DIV_SIZE'(1);

   logic [DIV_SIZE-1:0] w_period_clamped;
   logic [DIV_SIZE-1:0] r_period;
   logic [DIV_SIZE-1:0] r_count;

   // A zero period would never tick; treat it as one clock per step.
   assign w_period_clamped = (i_period == '0) ? c_ONE : i_period;

   // The step fires on the cycle the count sits at one.
   assign o_tick = i_run && (r_count == c_ONE);

   // Load, reload-on-tick and count-down; abort and reset both clear the timer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_period <= '0;
         r_count  <= '0;
      end else if (i_abort) begin
         r_period <= '0;
         r_count  <= '0;
      end else if (i_load) begin
         r_period <= w_period_clamped;
         r_count  <= w_period_clamped;
      end else if (i_run) begin
         r_count <= o_tick ? r_period : (r_count - c_ONE);
      end
   end

endmodule
`default_nettype wire

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_gen
//  Description : Incremental encoder emulator. Accepts signed step commands
//                over valid/ready, emits registered Gray-sequenced A/B edges
//                at a programmable period and tracks the emitted position.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_gen
   import quad_encoder_gen_pkg::*;
#(
   parameter int SIZE     = 8,
   parameter int DIV_SIZE = 16,
   parameter int POS_SIZE = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [SIZE-1:0]     cmd_steps,
   input  logic [DIV_SIZE-1:0] cmd_period,
   input  logic                stop,
   output logic                a,
   output logic                b,
   output logic                busy,
   output logic [POS_SIZE-1:0] pos
);

   localparam logic [SIZE-1:0]     c_STEP_ONE = SIZE'(1);
   localparam logic [POS_SIZE-1:0] c_POS_ONE  = POS_SIZE'(1);

   qe_state_t           r_state;
   logic                r_dir;
   logic [SIZE-1:0]     r_remaining;
   logic [1:0]          r_phase;
   logic                r_a;
   logic                r_b;
   logic [POS_SIZE-1:0] r_pos;

   logic                w_start;
   logic [SIZE-1:0]     w_abs_steps;
   logic                w_run;
   logic                w_abort;
   logic                w_tick;
   logic [1:0]          w_next_phase;
   logic [1:0]          w_next_ab;
   logic [POS_SIZE-1:0] w_next_pos;

   // Only non-zero commands start a run; zero-step commands are simply consumed.
   assign w_start     = (r_state == ST_IDLE) && cmd_valid && (cmd_steps != '0);
   // Magnitude as unsigned; the most negative value maps to 2^(SIZE-1).
   assign w_abs_steps = cmd_steps[SIZE-1] ? (~cmd_steps + c_STEP_ONE) : cmd_steps;
   // stop suppresses any step due in the same cycle.
   assign w_run       = (r_state == ST_RUN) && !stop;
   assign w_abort     = (r_state == ST_RUN) && stop;

   assign w_next_phase = (r_dir == c_DIR_FWD) ? (r_phase + 2'd1) : (r_phase - 2'd1);
   assign w_next_pos   = (r_dir == c_DIR_FWD) ? (r_pos + c_POS_ONE) : (r_pos - c_POS_ONE);
   assign w_next_ab    = phase_to_ab(w_next_phase);

   quad_step_timer #(
      .DIV_SIZE (DIV_SIZE)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_start),
      .i_period (cmd_period),
      .i_run    (w_run),
      .i_abort  (w_abort),
      .o_tick   (w_tick)
   );

   // Command handshake, step sequencing, phase/position tracking and A/B flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_dir       <= c_DIR_FWD;
         r_remaining <= '0;
         r_phase     <= 2'd0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_pos       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_dir       <= cmd_steps[SIZE-1] ? c_DIR_BWD : c_DIR_FWD;
                  r_remaining <= w_abs_steps;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_remaining <= '0;
                  r_state     <= ST_IDLE;
               end else if (w_tick) begin
                  r_phase     <= w_next_phase;
                  r_a         <= w_next_ab[1];
                  r_b         <= w_next_ab[0];
                  r_pos       <= w_next_pos;
                  r_remaining <= r_remaining - c_STEP_ONE;
                  if (r_remaining == c_STEP_ONE) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign pos       = r_pos;
   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_RUN);

endmodule
`default_nettype wire
